// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e : controller FSM states
//   FWD_*      : forward-select encodings driven on forward_rs / forward_rt
//   fwd_sel    : picks the youngest matching writer for one source operand
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  // Hit inputs already include the use_* and *_wr_en qualification.
  // A load sitting in EX has no data yet, so its match suppresses any older
  // forward: the load-use bubble resolves it instead.
  function automatic logic [1:0] fwd_sel(input logic ex_hit,
                                         input logic ex_load,
                                         input logic mem_hit,
                                         input logic wb_hit);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (ex_hit) begin
      sel = ex_load ? FWD_NONE : FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for pipeline statistics.
//   clk, reset_n : clock, asynchronous active-low reset (clears q)
//   inc          : add one this cycle (ignored once q is all ones)
//   clr          : synchronous clear, wins over inc
//   q            : current count
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / forwarding controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Selects RAW forwarding sources, inserts load-use bubbles, flushes on a
// mispredict, freezes the whole pipe during slow data-memory accesses and
// holds it forever after HLT or a memory timeout. Counts stall and flush cycles.
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   id_rs/id_rt, id_use_rs/rt       sources of the ID instruction and whether used
//   ex_/mem_/wb_wr_en, *_wr_reg     destination writers in EX, EX/MEM, MEM/WB
//   ex_is_load                      EX instruction is a load
//   ex_redirect                     EX resolved a wrong fetch path
//   dmem_req, dmem_ready            data-memory handshake of the MEM stage
//   halt_in                         HLT reached WB
//   forward_rs/rt                   00 regfile, 01 EX, 10 MEM, 11 WB
//   pc_write, if_id_write           PC and IF/ID enables
//   id_ex_bubble                    load a NOP into ID/EX
//   if_id_flush, id_ex_flush        clear IF/ID and ID/EX
//   freeze                          hold every pipeline register
//   mem_error                       sticky memory-timeout flag
//   halted                          controller is in HALT
//   stall_cnt, flush_cnt            saturating statistics counters
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; RAW stalls, flushes and forwarding active
// MEM_WAIT | data access outstanding; pipe frozen until dmem_ready/timeout
// HALT     | HLT retired or memory timed out; frozen until reset
module pipeline_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 2,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  ex_wr_en,
  input  logic [REG_ADDR_W-1:0] ex_wr_reg,
  input  logic                  ex_is_load,
  input  logic                  mem_wr_en,
  input  logic [REG_ADDR_W-1:0] mem_wr_reg,
  input  logic                  wb_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_wr_reg,
  input  logic                  ex_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  halt_in,
  output logic [1:0]            forward_rs,
  output logic [1:0]            forward_rt,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  freeze,
  output logic                  mem_error,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Timer holds completed wait cycles; HALT is taken when the count about to
  // be written reaches MEM_TIMEOUT, i.e. after exactly MEM_TIMEOUT MEM_WAIT cycles.
  localparam int              TMR_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic             mem_error_q, mem_error_d;

  logic rs_ex_hit, rs_mem_hit, rs_wb_hit;
  logic rt_ex_hit, rt_mem_hit, rt_wb_hit;
  logic raw_stall, mem_stall;
  logic stall_inc;

  assign rs_ex_hit  = id_use_rs && ex_wr_en  && (id_rs == ex_wr_reg);
  assign rs_mem_hit = id_use_rs && mem_wr_en && (id_rs == mem_wr_reg);
  assign rs_wb_hit  = id_use_rs && wb_wr_en  && (id_rs == wb_wr_reg);
  assign rt_ex_hit  = id_use_rt && ex_wr_en  && (id_rt == ex_wr_reg);
  assign rt_mem_hit = id_use_rt && mem_wr_en && (id_rt == mem_wr_reg);
  assign rt_wb_hit  = id_use_rt && wb_wr_en  && (id_rt == wb_wr_reg);

  always_comb begin
    if (FWD_EN != 0) begin
      raw_stall = ex_is_load && (rs_ex_hit || rt_ex_hit);
    end else begin
      raw_stall = rs_ex_hit || rs_mem_hit || rs_wb_hit ||
                  rt_ex_hit || rt_mem_hit || rt_wb_hit;
    end
  end

  // The cycle that launches a slow access is frozen already (RUN with the
  // request pending); the ready cycle of MEM_WAIT is not, so a redirect held
  // in EX is applied exactly then.
  assign mem_stall = !dmem_ready &&
                     ((state_q == MEM_WAIT) || ((state_q == RUN) && dmem_req));

  // Pipeline control, zero latency from state and inputs.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    freeze       = 1'b0;
    if (!reset_n) begin
      // keep the benign defaults while reset is held
    end else if (state_q == HALT) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      freeze      = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      freeze      = 1'b1;
    end else if (ex_redirect) begin
      // a load-use victim in ID is on the wrong path, so no bubble needed
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (raw_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    forward_rs = FWD_NONE;
    forward_rt = FWD_NONE;
    if (reset_n && (FWD_EN != 0)) begin
      forward_rs = fwd_sel(rs_ex_hit, ex_is_load, rs_mem_hit, rs_wb_hit);
      forward_rt = fwd_sel(rt_ex_hit, ex_is_load, rt_mem_hit, rt_wb_hit);
    end
  end

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: begin
        if (halt_in) begin
          state_d = HALT;
        end else if (dmem_req && !dmem_ready) begin
          state_d = MEM_WAIT;
          timer_d = '0;
        end
      end
      MEM_WAIT: begin
        timer_d = timer_inc;
        if (halt_in) begin
          state_d = HALT;
        end else if (dmem_ready) begin
          state_d = RUN;
        end else if (timer_inc == TMR_LIMIT) begin
          state_d     = HALT;
          mem_error_d = 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      timer_q     <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign mem_error = mem_error_q;
  assign halted    = (state_q == HALT);
  assign stall_inc = (state_q != HALT) && !pc_write;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .clr     (1'b0),
    .q       (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (if_id_flush),
    .clr     (1'b0),
    .q       (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Three instances share the stimulus:
//   ua : default parameters (forwarding on, 16-bit counters)
//   ub : FWD_EN=0
//   uc : CNT_W=4 (saturation)
module tb_pipeline_hazard_ctrl;

  logic clk, reset_n;
  logic [1:0] id_rs, id_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic id_use_rs, id_use_rt, ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
  logic ex_redirect, dmem_req, dmem_ready, halt_in;

  logic [1:0]  a_frs, a_frt, b_frs, b_frt, c_frs, c_frt;
  logic        a_pcw, a_ifw, a_bub, a_iff, a_ief, a_frz, a_merr, a_hlt;
  logic        b_pcw, b_ifw, b_bub, b_iff, b_ief, b_frz, b_merr, b_hlt;
  logic        c_pcw, c_ifw, c_bub, c_iff, c_ief, c_frz, c_merr, c_hlt;
  logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [3:0]  c_scnt, c_fcnt;

  int n_cmp = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl ua (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_wr_en(ex_wr_en),
    .ex_wr_reg(ex_wr_reg), .ex_is_load(ex_is_load), .mem_wr_en(mem_wr_en),
    .mem_wr_reg(mem_wr_reg), .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_in(halt_in), .forward_rs(a_frs), .forward_rt(a_frt),
    .pc_write(a_pcw), .if_id_write(a_ifw), .id_ex_bubble(a_bub),
    .if_id_flush(a_iff), .id_ex_flush(a_ief), .freeze(a_frz),
    .mem_error(a_merr), .halted(a_hlt), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  pipeline_hazard_ctrl #(.FWD_EN(0)) ub (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_wr_en(ex_wr_en),
    .ex_wr_reg(ex_wr_reg), .ex_is_load(ex_is_load), .mem_wr_en(mem_wr_en),
    .mem_wr_reg(mem_wr_reg), .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_in(halt_in), .forward_rs(b_frs), .forward_rt(b_frt),
    .pc_write(b_pcw), .if_id_write(b_ifw), .id_ex_bubble(b_bub),
    .if_id_flush(b_iff), .id_ex_flush(b_ief), .freeze(b_frz),
    .mem_error(b_merr), .halted(b_hlt), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) uc (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_wr_en(ex_wr_en),
    .ex_wr_reg(ex_wr_reg), .ex_is_load(ex_is_load), .mem_wr_en(mem_wr_en),
    .mem_wr_reg(mem_wr_reg), .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_in(halt_in), .forward_rs(c_frs), .forward_rt(c_frt),
    .pc_write(c_pcw), .if_id_write(c_ifw), .id_ex_bubble(c_bub),
    .if_id_flush(c_iff), .id_ex_flush(c_ief), .freeze(c_frz),
    .mem_error(c_merr), .halted(c_hlt), .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
  );

  typedef struct {
    int rs, rt, urs, urt;
    int exw, exr, exl;
    int memw, memr;
    int wbw, wbr;
    int redir;
    int frs, frt, pcw, bub, fl, bpcw;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 2'd0; id_rt = 2'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_wr_en = 1'b0; ex_wr_reg = 2'd0; ex_is_load = 1'b0;
    mem_wr_en = 1'b0; mem_wr_reg = 2'd0; wb_wr_en = 1'b0; wb_wr_reg = 2'd0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; halt_in = 1'b0;
  endtask

  // leaves the bench just after a negedge with reset released
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    id_rs = 2'(v.rs); id_rt = 2'(v.rt);
    id_use_rs = 1'(v.urs); id_use_rt = 1'(v.urt);
    ex_wr_en = 1'(v.exw); ex_wr_reg = 2'(v.exr); ex_is_load = 1'(v.exl);
    mem_wr_en = 1'(v.memw); mem_wr_reg = 2'(v.memr);
    wb_wr_en = 1'(v.wbw); wb_wr_reg = 2'(v.wbr);
    ex_redirect = 1'(v.redir);
  endtask

  initial begin
    int exp_stall, exp_flush, exp_b_stall, edges;

    //          rs rt ur ut  exw exr exl memw memr wbw wbr rd  frs frt pcw bub fl bpcw
    vecs[0]  = '{1, 2, 1, 1,  0,  0,  0,  0,   0,   0,  0,  0,  0,  0,  1,  0, 0, 1};
    vecs[1]  = '{1, 2, 1, 1,  1,  1,  0,  0,   0,   0,  0,  0,  1,  0,  1,  0, 0, 0};
    vecs[2]  = '{1, 2, 1, 1,  0,  0,  0,  1,   2,   0,  0,  0,  0,  2,  1,  0, 0, 0};
    vecs[3]  = '{1, 2, 1, 1,  0,  0,  0,  0,   0,   1,  1,  0,  3,  0,  1,  0, 0, 0};
    vecs[4]  = '{1, 1, 1, 1,  1,  1,  0,  1,   1,   1,  1,  0,  1,  1,  1,  0, 0, 0};
    vecs[5]  = '{3, 0, 1, 1,  0,  0,  0,  1,   3,   1,  3,  0,  2,  0,  1,  0, 0, 0};
    vecs[6]  = '{1, 2, 1, 1,  1,  2,  1,  0,   0,   0,  0,  0,  0,  0,  0,  1, 0, 0};
    vecs[7]  = '{1, 2, 1, 1,  1,  2,  1,  1,   2,   0,  0,  0,  0,  0,  0,  1, 0, 0};
    vecs[8]  = '{0, 2, 1, 0,  1,  2,  1,  0,   0,   0,  0,  0,  0,  0,  1,  0, 0, 1};
    vecs[9]  = '{1, 2, 1, 1,  0,  1,  1,  0,   0,   0,  0,  0,  0,  0,  1,  0, 0, 1};
    vecs[10] = '{1, 2, 1, 1,  1,  2,  1,  0,   0,   0,  0,  1,  0,  0,  1,  0, 1, 1};
    vecs[11] = '{3, 2, 1, 1,  1,  3,  0,  0,   0,   0,  0,  1,  1,  0,  1,  0, 1, 1};
    vecs[12] = '{0, 0, 1, 1,  0,  0,  0,  0,   0,   1,  0,  0,  3,  3,  1,  0, 0, 0};
    vecs[13] = '{1, 3, 1, 1,  1,  2,  0,  1,   1,   1,  3,  0,  2,  3,  1,  0, 0, 0};
    vecs[14] = '{1, 2, 0, 1,  1,  1,  0,  0,   0,   0,  0,  0,  0,  0,  1,  0, 0, 1};

    // ---- reset held: outputs benign even with hazardous inputs
    clear_inputs();
    reset_n = 1'b0;
    #2;
    id_rs = 2'd1; id_use_rs = 1'b1; id_rt = 2'd2; id_use_rt = 1'b1;
    ex_wr_en = 1'b1; ex_wr_reg = 2'd2; ex_is_load = 1'b1;
    mem_wr_en = 1'b1; mem_wr_reg = 2'd1; ex_redirect = 1'b1;
    dmem_req = 1'b1; halt_in = 1'b1;
    #1;
    chk("rst_pc_write", 32'(a_pcw), 1);
    chk("rst_if_id_write", 32'(a_ifw), 1);
    chk("rst_bubble", 32'(a_bub), 0);
    chk("rst_flush", 32'({a_iff, a_ief}), 0);
    chk("rst_freeze", 32'(a_frz), 0);
    chk("rst_forward_rs", 32'(a_frs), 0);
    @(negedge clk);
    #1;
    chk("rst_halted", 32'(a_hlt), 0);
    chk("rst_mem_error", 32'(a_merr), 0);
    chk("rst_stall_cnt", 32'(a_scnt), 0);
    chk("rst_flush_cnt", 32'(a_fcnt), 0);

    // ---- table of single-cycle RUN-state vectors
    do_reset();
    exp_stall = 0; exp_flush = 0; exp_b_stall = 0;
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d_forward_rs", i), 32'(a_frs), vecs[i].frs);
      chk($sformatf("v%0d_forward_rt", i), 32'(a_frt), vecs[i].frt);
      chk($sformatf("v%0d_pc_write", i), 32'(a_pcw), vecs[i].pcw);
      chk($sformatf("v%0d_if_id_write", i), 32'(a_ifw), vecs[i].pcw);
      chk($sformatf("v%0d_bubble", i), 32'(a_bub), vecs[i].bub);
      chk($sformatf("v%0d_if_id_flush", i), 32'(a_iff), vecs[i].fl);
      chk($sformatf("v%0d_id_ex_flush", i), 32'(a_ief), vecs[i].fl);
      chk($sformatf("v%0d_freeze", i), 32'(a_frz), 0);
      chk($sformatf("v%0d_nofwd_pc_write", i), 32'(b_pcw), vecs[i].bpcw);
      chk($sformatf("v%0d_nofwd_forwards", i), 32'({b_frs, b_frt}), 0);
      if (vecs[i].pcw == 0) exp_stall++;
      if (vecs[i].fl == 1) exp_flush++;
      if (vecs[i].bpcw == 0) exp_b_stall++;
      @(negedge clk);
    end
    clear_inputs();
    #1;
    chk("tbl_stall_cnt", 32'(a_scnt), exp_stall);
    chk("tbl_flush_cnt", 32'(a_fcnt), exp_flush);
    chk("tbl_nofwd_stall_cnt", 32'(b_scnt), exp_b_stall);
    chk("tbl_nofwd_flush_cnt", 32'(b_fcnt), exp_flush);

    // ---- load-use: one bubble, then forward from MEM
    do_reset();
    ex_wr_en = 1'b1; ex_wr_reg = 2'd2; ex_is_load = 1'b1;
    id_rt = 2'd2; id_use_rt = 1'b1; id_rs = 2'd0; id_use_rs = 1'b1;
    #1;
    chk("lu_bubble", 32'(a_bub), 1);
    chk("lu_pc_write", 32'(a_pcw), 0);
    @(negedge clk);
    ex_wr_en = 1'b0; ex_is_load = 1'b0; mem_wr_en = 1'b1; mem_wr_reg = 2'd2;
    #1;
    chk("lu_fwd_rt_mem", 32'(a_frt), 2);
    chk("lu_after_pc_write", 32'(a_pcw), 1);
    chk("lu_after_bubble", 32'(a_bub), 0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("lu_stall_cnt", 32'(a_scnt), 1);

    // ---- FWD_EN=0: WB writer stalls until it retires
    do_reset();
    wb_wr_en = 1'b1; wb_wr_reg = 2'd3; id_rs = 2'd3; id_use_rs = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("nf_pc_write", 32'(b_pcw), 0);
      chk("nf_bubble", 32'(b_bub), 1);
      chk("nf_forward_rs", 32'(b_frs), 0);
      chk("nf_fwd_dut_forward_rs", 32'(a_frs), 3);
      @(negedge clk);
    end
    wb_wr_en = 1'b0;
    #1;
    chk("nf_release_pc_write", 32'(b_pcw), 1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("nf_stall_cnt", 32'(b_scnt), 2);

    // ---- slow memory with a held redirect
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mw%0d_freeze", k), 32'(a_frz), 1);
      chk($sformatf("mw%0d_flush", k), 32'({a_iff, a_ief}), 0);
      chk($sformatf("mw%0d_pc_write", k), 32'(a_pcw), 0);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_ready_freeze", 32'(a_frz), 0);
    chk("mw_ready_flush", 32'({a_iff, a_ief}), 3);
    chk("mw_ready_pc_write", 32'(a_pcw), 1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("mw_stall_cnt", 32'(a_scnt), 3);
    chk("mw_flush_cnt", 32'(a_fcnt), 1);
    chk("mw_back_to_run", 32'(a_frz), 0);

    // ---- memory timeout -> HALT with sticky mem_error
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    edges = 0;
    #1;
    while (!a_hlt && edges < 40) begin
      @(negedge clk);
      edges++;
      #1;
    end
    chk("to_edges_to_halt", 32'(edges), 16);
    chk("to_mem_error", 32'(a_merr), 1);
    ex_redirect = 1'b1;
    #1;
    chk("to_halt_pc_write", 32'(a_pcw), 0);
    chk("to_halt_if_id_write", 32'(a_ifw), 0);
    chk("to_halt_freeze", 32'(a_frz), 1);
    chk("to_halt_flush", 32'({a_iff, a_ief}), 0);
    dmem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("to_halt_sticky", 32'(a_hlt), 1);
    chk("to_mem_error_sticky", 32'(a_merr), 1);
    chk("to_stall_cnt", 32'(a_scnt), 16);
    reset_n = 1'b0;
    #1;
    chk("to_reset_mem_error", 32'(a_merr), 0);
    chk("to_reset_halted", 32'(a_hlt), 0);

    // ---- halt_in from RUN
    do_reset();
    halt_in = 1'b1;
    @(negedge clk);
    halt_in = 1'b0;
    #1;
    chk("hlt_halted", 32'(a_hlt), 1);
    chk("hlt_no_mem_error", 32'(a_merr), 0);

    // ---- 4-bit counter saturation, then async reset mid MEM_WAIT
    do_reset();
    ex_wr_en = 1'b1; ex_wr_reg = 2'd2; ex_is_load = 1'b1;
    id_rt = 2'd2; id_use_rt = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 14) begin
        #1;
        chk("sat_cnt_14", 32'(c_scnt), 14);
      end
    end
    #1;
    chk("sat_cnt_held", 32'(c_scnt), 15);
    chk("sat_wide_cnt", 32'(a_scnt), 20);
    clear_inputs();
    dmem_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("sat_in_mem_wait", 32'(c_frz), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_stall_cnt", 32'(c_scnt), 0);
    chk("arst_freeze", 32'(c_frz), 0);
    chk("arst_pc_write", 32'(c_pcw), 1);
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    #1;
    chk("arst_state_run", 32'(c_frz), 0);
    chk("arst_halted", 32'(c_hlt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
